prefix_adder_pipe: RTL and testbench
====================================

// Module: prefix_adder_pipe
// PURPOSE
//  Parametrised pipelined Han-Carlson prefix adder/subtractor with valid/ready flow control.
//  Sits between the PID error/accumulator datapath and its consumers; replaces fixed 32-bit adders.
//  Accepts one operation per cycle; PIPE register stages; reports carry and signed overflow.
// PARAMETERS
//  WIDTH  32  operand width; power of two, 8..64
//  PIPE   2   register stages, 1..3; latency = PIPE cycles
// PORTS
//  i_clk    in   1      clock; all state updates on rising edge
//  i_rst    in   1      synchronous, active-high reset
//  i_a      in   WIDTH  operand A
//  i_b      in   WIDTH  operand B
//  i_c      in   1      carry-in (add) / borrow-in (sub)
//  i_sub    in   1      0: A+B+c  1: A-B-c
//  i_valid  in   1      input beat valid
//  o_ready  out  1      block can accept a beat this cycle
//  o_s      out  WIDTH  sum/difference
//  o_c      out  1      carry-out (sub: 1 = no borrow)
//  o_v      out  1      signed overflow
//  o_valid  out  1      output beat valid
//  i_ready  in   1      downstream accepts output beat
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high; all stage valids, o_valid=0; o_s=0, o_c=0, o_v=0.
//  Reset mid-operation: all in-flight beats discarded; o_valid=0 the cycle after i_rst sampled high.
//  Arithmetic: B' = i_sub ? ~i_b : i_b; cin = i_sub ? ~i_c : i_c; {o_c,o_s} = i_a + B' + cin.
//  o_v = carry into MSB XOR carry out of MSB (two's-complement overflow).
//  Prefix tree: level 0 P=A^B', G=A&B'; cin merged into G[0]; odd-bit Kogge-Stone of
//   log2(WIDTH) levels on odd bits; final level fills even bits; o_s[i] = P[i]^G[i-1].
//  Stage cuts: PIPE=1: register outputs only. PIPE=2: + cut after prefix level log2(WIDTH)/2.
//   PIPE=3: + cut after level 0 (P/G). Each cut registers all live P/G/operand bits plus valid.
//  Handshake: beat accepted when i_valid & o_ready; beat delivered when o_valid & i_ready.
//   Stage k enable: en_k = ~v_k | en_(k+1); last stage: en = ~o_valid | i_ready.
//   o_ready = en of first stage (combinational from i_ready; no bubbles).
//  Throughput 1 beat/cycle while i_ready=1; latency exactly PIPE cycles from accept to o_valid.
//  Backpressure: i_ready=0 holds o_s/o_c/o_v/o_valid stable; stages fill; o_ready falls once
//   all PIPE stages hold valid beats; no beat dropped or duplicated.
//  Simultaneous accept+deliver at full occupancy: legal, occupancy unchanged.
//  i_valid=0 with o_ready=1: empty slot advances; o_s/o_c/o_v hold last delivered values.
//  Beats emerge in acceptance order; data regs load only when their valid loads 1.
// CONFIGURATION
//  PREFIX_ADDER_SAT_EN defined: on o_v=1, o_s clamps to signed max (0x7F..F) if result
//   overflowed positive, signed min (0x80..0) if negative; o_v and o_c still report raw flags.
//   Clamp applied in final stage; latency unchanged.
//  Undefined: o_s wraps modulo 2^WIDTH; no clamp logic synthesised.
// TESTING (WIDTH=32, PIPE=2 unless noted)
//  1. add a=0xFFFFFFFF b=0 c=1 -> after 2 cycles o_s=0x00000000 o_c=1 o_v=0 o_valid=1.
//  2. add a=0x7FFFFFFF b=1 c=0 -> o_s=0x80000000 o_v=1; with PREFIX_ADDER_SAT_EN o_s=0x7FFFFFFF.
//  3. sub a=5 b=7 c=0 -> o_s=0xFFFFFFFE o_c=0 o_v=0; sub a=0x80000000 b=1 -> o_v=1, sat 0x80000000.
//  4. stream 16 random beats, i_ready toggling 1/0 per cycle -> all 16 outputs in order, match model.
//  5. hold i_ready=0, drive i_valid=1 -> o_ready=0 after 2 accepts; release -> both beats out in order.
//  6. i_rst=1 with 2 beats in flight -> next cycle o_valid=0; PIPE=1 and PIPE=3, WIDTH=8/64 sweeps pass.

Source files
------------

// File: rtl/prefix_adder_pipe.sv
// rtl/prefix_adder_pipe.sv - pipelined Han-Carlson prefix adder/subtractor with valid/ready flow control
// Optional feature macro: PREFIX_ADDER_SAT_EN (clamp o_s to the signed range on overflow).
module prefix_adder_pipe #(
   parameter int WIDTH = 32,
   parameter int PIPE  = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c,
   input  logic             i_sub,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_c,
   output logic             o_v,
   output logic             o_valid,
   input  logic             i_ready
);
   localparam int LOG  = $clog2(WIDTH);
   localparam int HALF = LOG / 2;
   localparam logic [WIDTH-1:0] ODD_BITS  = {(WIDTH/2){2'b10}};
   localparam logic [WIDTH-1:0] EVEN_HIGH = {{(WIDTH/2-1){2'b01}}, 2'b00};

   // p0 is the untouched half-sum needed for the final XOR; p/g evolve through the tree
   typedef struct packed {
      logic             cin;
      logic [WIDTH-1:0] p0;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
   } pg_t;

   // Kogge-Stone levels lo..hi applied to odd bits only; level l spans 2^(l-1)
   function automatic pg_t ks_levels(input pg_t x, input int lo, input int hi);
      pg_t y;
      logic [WIDTH-1:0] m;
      logic [WIDTH-1:0] gs;
      logic [WIDTH-1:0] ps;
      y = x;
      for (int l = 1; l <= LOG; l++) begin
         if (l >= lo && l <= hi) begin
            m   = ODD_BITS & ({WIDTH{1'b1}} << (1 << (l - 1)));
            gs  = y.g << (1 << (l - 1));
            ps  = y.p << (1 << (l - 1));
            y.g = y.g | (y.p & gs & m);
            y.p = (y.p & ~m) | (y.p & ps & m);
         end
      end
      return y;
   endfunction

   // remaining odd levels, even-bit fill, then sum and flags as {v, c, s}
   function automatic logic [WIDTH+1:0] back_end(input pg_t x);
      pg_t y;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] s;
      y = ks_levels(x, HALF + 1, LOG);
      g = y.g | (y.p & (y.g << 1) & EVEN_HIGH);
      s = y.p0 ^ {g[WIDTH-2:0], y.cin};
      return {g[WIDTH-2] ^ g[WIDTH-1], g[WIDTH-1], s};
   endfunction

   logic             en_a;
   logic             en_b;
   logic             en_out;
   pg_t              front;
   pg_t              a_out;
   logic             a_vld;
   pg_t              mid;
   pg_t              b_out;
   logic             b_vld;
   logic [WIDTH+1:0] res;
   logic [WIDTH-1:0] res_s;

   always_comb begin
      logic [WIDTH-1:0] bx;
      logic             cin;
      bx        = i_sub ? ~i_b : i_b;
      cin       = i_sub ? ~i_c : i_c;
      front.cin = cin;
      front.p0  = i_a ^ bx;
      front.p   = i_a ^ bx;
      front.g   = (i_a & bx) | {{(WIDTH-1){1'b0}}, (i_a[0] ^ bx[0]) & cin};
   end

   generate
      if (PIPE == 3) begin : g_cut_a
         pg_t  a_q;
         logic a_v;
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               a_v <= 1'b0;
            end else if (en_a) begin
               a_v <= i_valid;
               if (i_valid) a_q <= front;
            end
         end
         assign a_out = a_q;
         assign a_vld = a_v;
         assign en_a  = ~a_v | en_b;
      end else begin : g_no_cut_a
         assign a_out = front;
         assign a_vld = i_valid;
         assign en_a  = en_b;
      end
   endgenerate

   assign mid = ks_levels(a_out, 1, HALF);

   generate
      if (PIPE >= 2) begin : g_cut_b
         pg_t  b_q;
         logic b_v;
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               b_v <= 1'b0;
            end else if (en_b) begin
               b_v <= a_vld;
               if (a_vld) b_q <= mid;
            end
         end
         assign b_out = b_q;
         assign b_vld = b_v;
         assign en_b  = ~b_v | en_out;
      end else begin : g_no_cut_b
         assign b_out = mid;
         assign b_vld = a_vld;
         assign en_b  = en_out;
      end
   endgenerate

   assign en_out  = ~o_valid | i_ready;
   assign o_ready = en_a;
   assign res     = back_end(b_out);

   always_comb begin
      res_s = res[WIDTH-1:0];
`ifdef PREFIX_ADDER_SAT_EN
      // a set sign bit on overflow means the true result went past the positive limit
      if (res[WIDTH+1])
         res_s = res[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_s     <= '0;
         o_c     <= 1'b0;
         o_v     <= 1'b0;
      end else if (en_out) begin
         o_valid <= b_vld;
         if (b_vld) begin
            o_s <= res_s;
            o_c <= res[WIDTH];
            o_v <= res[WIDTH+1];
         end
      end
   end
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// tb/tb_prefix_adder_pipe.sv - scoreboard bench for prefix_adder_pipe against an arithmetic model
module tb_prefix_adder_pipe;
   localparam int W = 32;
   localparam int P = 2;
   localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (W - 1));

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic         in_ready;
   logic [W-1:0] s;
   logic         c;
   logic         v;
   logic         out_valid;

   exp_t sb[$];
   exp_t last_exp;
   int   n_tests = 0;
   int   n_fail = 0;

   prefix_adder_pipe #(.WIDTH(W), .PIPE(P)) dut (
      .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_c(cin), .i_sub(sub),
      .i_valid(in_valid), .o_ready(in_ready), .o_s(s), .o_c(c), .o_v(v),
      .o_valid(out_valid), .i_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb_op);
      exp_t        e;
      logic [W:0]  full;
      longint      r;
      if (!sb_op) begin
         full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
         e.c  = full[W];
         r    = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      end else begin
         full = {1'b0, x} - {1'b0, y} - (W+1)'(ci);
         e.c  = ~full[W];
         r    = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
      end
      e.s = full[W-1:0];
      e.v = (r > SMAX) || (r < SMIN);
`ifdef PREFIX_ADDER_SAT_EN
      if (e.v) e.s = (r > SMAX) ? W'(SMAX) : W'(SMIN);
`endif
      return e;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // monitor: pops one expected beat for every delivered output beat
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            last_exp = e;
            check("sum", s, e.s);
            check("carry", c, e.c);
            check("ovf", v, e.v);
         end
      end
   end

   task automatic set_rand();
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
   endtask

   task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic op);
      a = x; b = y; cin = ci; sub = op; in_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(model(x, y, ci, op));
            step();
            in_valid = 1'b0;
            return;
         end
         step();
      end
      in_valid = 1'b0;
      check("send_timeout", 1, 0);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 60 && sb.size() != 0; k++) step();
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin
      int acc;
      int lat;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_s", s, 0);
      check("rst_c", c, 0);
      check("rst_v", v, 0);
      check("rst_ready", in_ready, 1);
      step();

      // directed vectors, with latency measured on the first one
      send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
      lat = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) break;
         lat++;
         step();
      end
      check("latency", lat, P);
      step();
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      send(32'h5, 32'h7, 1'b0, 1'b1);
      send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
      send(32'h0, 32'h0, 1'b1, 1'b1);
      send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      drain();

      // 16 random beats with i_ready toggling each cycle
      acc = 0;
      in_valid = 1'b1;
      set_rand();
      for (int k = 0; k < 200 && acc < 16; k++) begin
         out_ready = k[0];
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(model(a, b, cin, sub));
            acc++;
            step();
            set_rand();
         end else begin
            step();
         end
      end
      check("toggle_accepts", acc, 16);
      drain();

      // backpressure fill: only P beats fit while i_ready is low
      out_ready = 1'b0;
      in_valid  = 1'b1;
      acc = 0;
      set_rand();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(model(a, b, cin, sub));
            acc++;
            step();
            set_rand();
         end else begin
            step();
         end
      end
      @(negedge clk);
      check("bp_accepts", acc, P);
      check("bp_ready_low", in_ready, 0);
      step();
      drain();
      repeat (3) step();
      @(negedge clk);
      check("idle_hold_s", s, last_exp.s);
      check("idle_valid", out_valid, 0);
      step();

      // long random run with random valid and ready
      acc = 0;
      set_rand();
      for (int k = 0; k < 600; k++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            sb.push_back(model(a, b, cin, sub));
            acc++;
            step();
            set_rand();
         end else begin
            step();
         end
      end
      drain();

      // reset with beats in flight discards them
      out_ready = 1'b0;
      in_valid  = 1'b1;
      repeat (4) step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (6) step();
      @(negedge clk);
      check("midrst_quiet", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
